// File: rtl/prewish5k_mask_arbiter.sv
// Round-robin arbiter sharing the mentor's single mask-load port among four requesters.
// Each request is buffered, granted in turn, and followed by a programmable hold-off.
module prewish5k_mask_arbiter #(
    parameter int HOLD_BITS   = 16,
    parameter int HOLD_CYCLES = 1000,
    parameter int ALIVE_BITS  = 22
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [3:0]  STB_I,
    input  logic [31:0] DAT_I,
    output logic [3:0]  ACK_O,
    output logic [3:0]  OVR_O,
    output logic        STB_O,
    output logic [7:0]  DAT_O,
    output logic [1:0]  GNT_O,
    output logic        o_alive
);

    localparam logic [HOLD_BITS-1:0] HOLD_LOAD = HOLD_BITS'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLD
    } state_t;

    state_t                 state;
    logic [3:0]             pend;
    logic [7:0]             mask_buf [4];
    logic [1:0]             ptr;
    logic [HOLD_BITS-1:0]   cnt;
    logic [ALIVE_BITS-1:0]  alive_cnt;

    logic                   grant_now;
    logic                   found;
    logic [1:0]             sel;
    logic [1:0]             cand;
    logic [3:0]             grant_vec;

    // Search starts just past the last winner, so the pointer's reset value of 3 favours requester 0.
    always_comb begin
        sel   = ptr;
        cand  = ptr;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cand = ptr + 2'(i);
            if (!found && pend[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
        grant_now = (state == IDLE) && (pend != 4'b0000);
        grant_vec = grant_now ? (4'b0001 << sel) : 4'b0000;
    end

    // A strobe landing on the granted requester re-arms pend without flagging an overrun.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            pend  <= 4'b0000;
            OVR_O <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                mask_buf[k] <= 8'h00;
            end
        end else begin
            pend  <= (pend & ~grant_vec) | STB_I;
            OVR_O <= STB_I & pend & ~grant_vec;
            for (int k = 0; k < 4; k++) begin
                if (STB_I[k]) begin
                    mask_buf[k] <= DAT_I[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state <= IDLE;
            ptr   <= 2'd3;
            cnt   <= '0;
            STB_O <= 1'b0;
            ACK_O <= 4'b0000;
            DAT_O <= 8'h00;
            GNT_O <= 2'd0;
        end else begin
            STB_O <= 1'b0;
            ACK_O <= 4'b0000;
            case (state)
                IDLE: begin
                    if (grant_now) begin
                        DAT_O <= mask_buf[sel];
                        GNT_O <= sel;
                        ptr   <= sel;
                        STB_O <= 1'b1;
                        ACK_O <= grant_vec;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (HOLD_CYCLES == 0) begin
                        state <= IDLE;
                    end else begin
                        cnt   <= HOLD_LOAD;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt <= 1) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            alive_cnt <= '0;
        end else begin
            alive_cnt <= alive_cnt + 1'b1;
        end
    end

    assign o_alive = alive_cnt[ALIVE_BITS-1];

    // The ISSUE state always separates two grants, so the mentor strobe can never repeat back to back.
    a_no_back_to_back: assert property (@(posedge CLK_I) disable iff (!RST_I) STB_O |=> !STB_O);
    a_ack_with_stb:    assert property (@(posedge CLK_I) disable iff (!RST_I)
                                        (ACK_O != 4'b0000) |-> (STB_O && $onehot(ACK_O)));

endmodule
